// File: rtl/grf_if.sv
// GRF bus: controller-side write/read request and
// register-file read data plus commit trace.
interface grf_if;
  logic        we;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] pc;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_wa;
  logic [31:0] trace_wd;
  logic [31:0] wr_count;

  modport master (
    output we, ra1, ra2, wa, wd, pc,
    input  rd1, rd2, trace_valid, trace_pc,
    input  trace_wa, trace_wd, wr_count
  );

  modport slave (
    input  we, ra1, ra2, wa, wd, pc,
    output rd1, rd2, trace_valid, trace_pc,
    output trace_wa, trace_wd, wr_count
  );
endinterface

// File: rtl/grf.sv
// GRF: 32x32 register file, two combinational read
// ports, optional write bypass, commit trace and counter.
module grf #(
  parameter bit BYPASS = 1'b1
) (
  input logic  clk,
  input logic  reset,
  grf_if.slave bus
);
  logic [31:0] r_regs [32];
  logic        r_tv;
  logic [31:0] r_tpc;
  logic [4:0]  r_twa;
  logic [31:0] r_twd;
  logic [31:0] r_wr_count;

  logic        w_wr;
  logic        w_byp1;
  logic        w_byp2;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;

  assign w_wr   = bus.we && !reset;
  assign w_byp1 = BYPASS && w_wr && (bus.wa != 5'd0)
                  && (bus.wa == bus.ra1);
  assign w_byp2 = BYPASS && w_wr && (bus.wa != 5'd0)
                  && (bus.wa == bus.ra2);

  // Storage: reset clears all, address 0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (bus.we && bus.wa != 5'd0) begin
      r_regs[bus.wa] <= bus.wd;
    end
  end

  // Commit trace and write counter, zero-writes included.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tv       <= 1'b0;
      r_tpc      <= '0;
      r_twa      <= '0;
      r_twd      <= '0;
      r_wr_count <= '0;
    end else begin
      r_tv <= bus.we;
      if (bus.we) begin
        r_tpc      <= bus.pc;
        r_twa      <= bus.wa;
        r_twd      <= bus.wd;
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  // Read mux: address 0 hardwired, then optional bypass.
  always_comb begin
    w_rd1 = (bus.ra1 == 5'd0) ? '0 : r_regs[bus.ra1];
    w_rd2 = (bus.ra2 == 5'd0) ? '0 : r_regs[bus.ra2];
    if (w_byp1) w_rd1 = bus.wd;
    if (w_byp2) w_rd2 = bus.wd;
  end

  assign bus.rd1         = w_rd1;
  assign bus.rd2         = w_rd2;
  assign bus.trace_valid = r_tv;
  assign bus.trace_pc    = r_tpc;
  assign bus.trace_wa    = r_twa;
  assign bus.trace_wd    = r_twd;
  assign bus.wr_count    = r_wr_count;
endmodule

// File: tb/tb_grf.sv
// GRF bench: bypass and non-bypass instances driven
// identically, checked against a behavioural model.
module tb_grf;
  logic clk;
  logic t_rst;
  logic t_we;
  logic [4:0] t_ra1, t_ra2, t_wa;
  logic [31:0] t_wd, t_pc;
  logic t_pre;

  int n_cmp = 0;
  int n_bad = 0;

  grf_if b1 ();
  grf_if b0 ();

  assign b1.we = t_we;  assign b0.we = t_we;
  assign b1.ra1 = t_ra1; assign b0.ra1 = t_ra1;
  assign b1.ra2 = t_ra2; assign b0.ra2 = t_ra2;
  assign b1.wa = t_wa;  assign b0.wa = t_wa;
  assign b1.wd = t_wd;  assign b0.wd = t_wd;
  assign b1.pc = t_pc;  assign b0.pc = t_pc;

  grf #(.BYPASS(1'b1)) u1 (.clk(clk), .reset(t_rst), .bus(b1));
  grf #(.BYPASS(1'b0)) u0 (.clk(clk), .reset(t_rst), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of architectural state.
  logic [31:0] m_regs [32];
  logic        m_ok = 1'b0;
  logic        m_tv;
  logic [31:0] m_tpc, m_twd, m_cnt;
  logic [4:0]  m_twa;

  always @(posedge clk) begin
    if (t_rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_tv <= 1'b0; m_tpc <= 0; m_twa <= 0; m_twd <= 0;
      m_cnt <= 0; m_ok <= 1'b1;
    end else begin
      m_tv <= t_we;
      if (t_we) begin
        if (t_wa != 0) m_regs[t_wa] <= t_wd;
        m_tpc <= t_pc; m_twa <= t_wa; m_twd <= t_wd;
        m_cnt <= m_cnt + 1;
      end else if (t_pre) begin
        m_cnt <= 32'hFFFF_FFFF;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                         input bit byp);
    if (a == 0) return 32'd0;
    if (byp && t_we && !t_rst && t_wa == a) return t_wd;
    return m_regs[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("u1.rd1", b1.rd1, exp_rd(t_ra1, 1'b1));
      chk("u1.rd2", b1.rd2, exp_rd(t_ra2, 1'b1));
      chk("u0.rd1", b0.rd1, exp_rd(t_ra1, 1'b0));
      chk("u0.rd2", b0.rd2, exp_rd(t_ra2, 1'b0));
      chk("u1.tv", {31'd0, b1.trace_valid}, {31'd0, m_tv});
      chk("u0.tv", {31'd0, b0.trace_valid}, {31'd0, m_tv});
      chk("u1.tpc", b1.trace_pc, m_tpc);
      chk("u1.twa", {27'd0, b1.trace_wa}, {27'd0, m_twa});
      chk("u1.twd", b1.trace_wd, m_twd);
      chk("u0.twd", b0.trace_wd, m_twd);
      if (!t_pre) begin
        chk("u1.cnt", b1.wr_count, m_cnt);
        chk("u0.cnt", b0.wr_count, m_cnt);
      end
    end
  end

  task automatic cyc(input logic rst, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd,
                     input logic [31:0] pc,
                     input logic [4:0] ra1, input logic [4:0] ra2);
    @(posedge clk); #1;
    t_rst = rst; t_we = we; t_wa = wa; t_wd = wd; t_pc = pc;
    t_ra1 = ra1; t_ra2 = ra2;
    @(negedge clk);
  endtask

  initial begin
    t_rst = 1; t_we = 0; t_wa = 0; t_wd = 0; t_pc = 0;
    t_ra1 = 0; t_ra2 = 0; t_pre = 0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      if (i == 3) begin
        chk("lit.rst.rd1", b1.rd1, 32'd0);
        chk("lit.rst.tv", {31'd0, b1.trace_valid}, 32'd0);
        chk("lit.rst.cnt", b1.wr_count, 32'd0);
      end
    end

    cyc(0, 1, 8, 32'h1234_5678, 32'h3000, 8, 0);
    chk("lit.byp8", b1.rd1, 32'h1234_5678);
    chk("lit.nobyp8", b0.rd1, 32'd0);
    cyc(0, 0, 0, 0, 0, 8, 8);
    chk("lit.rd8", b0.rd1, 32'h1234_5678);
    chk("lit.tv8", {31'd0, b1.trace_valid}, 32'd1);
    chk("lit.tpc8", b1.trace_pc, 32'h3000);
    chk("lit.twa8", {27'd0, b1.trace_wa}, 32'd8);
    chk("lit.cnt1", b1.wr_count, 32'd1);

    cyc(0, 1, 0, 32'hFFFF_FFFF, 32'h3004, 0, 0);
    chk("lit.z.pre", b1.rd1, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit.z.post", b1.rd2, 32'd0);
    chk("lit.z.twd", b1.trace_wd, 32'hFFFF_FFFF);
    chk("lit.z.cnt", b1.wr_count, 32'd2);
    cyc(0, 0, 0, 0, 0, 8, 0);
    chk("lit.tv.pulse", {31'd0, b1.trace_valid}, 32'd0);

    cyc(0, 1, 5, 32'd1, 32'h3008, 1, 2);
    cyc(0, 1, 5, 32'd2, 32'h300C, 5, 5);
    chk("lit.b1.rd1", b1.rd1, 32'd2);
    chk("lit.b1.rd2", b1.rd2, 32'd2);
    chk("lit.b0.rd1", b0.rd1, 32'd1);
    chk("lit.b0.rd2", b0.rd2, 32'd1);
    cyc(0, 0, 0, 0, 0, 5, 5);
    chk("lit.b0.post", b0.rd1, 32'd2);

    cyc(0, 1, 31, 32'hAAAA_5555, 32'h3010, 30, 8);
    cyc(0, 1, 30, 32'h0F0F_0F0F, 32'h3014, 31, 30);
    cyc(0, 1, 1, 32'h8000_0001, 32'h3018, 31, 2);
    cyc(0, 0, 0, 0, 0, 1, 31);

    cyc(1, 1, 31, 32'h3008, 32'h301C, 31, 8);
    chk("lit.rst.nobyp", b1.rd1, 32'hAAAA_5555);
    cyc(0, 0, 0, 0, 0, 31, 8);
    chk("lit.r31", b1.rd1, 32'd0);
    chk("lit.r8", b1.rd2, 32'd0);
    chk("lit.rst.tv2", {31'd0, b1.trace_valid}, 32'd0);
    chk("lit.rst.cnt2", b1.wr_count, 32'd0);

    cyc(0, 1, 9, 32'hCAFE_F00D, 32'h4000, 9, 0);
    cyc(0, 1, 10, 32'h0000_BEEF, 32'h4004, 9, 10);

    @(posedge clk); #1;
    t_we = 0; t_pre = 1; t_ra1 = 9; t_ra2 = 10;
    force u1.r_wr_count = 32'hFFFF_FFFF;
    force u0.r_wr_count = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release u1.r_wr_count;
    release u0.r_wr_count;
    t_pre = 0;
    @(negedge clk);
    chk("lit.pre.cnt", b1.wr_count, 32'hFFFF_FFFF);
    cyc(0, 1, 11, 32'h1111_2222, 32'h4008, 9, 10);
    cyc(0, 0, 0, 0, 0, 11, 9);
    chk("lit.wrap", b1.wr_count, 32'd0);
    chk("lit.wrap0", b0.wr_count, 32'd0);
    chk("lit.keep9", b1.rd2, 32'hCAFE_F00D);
    chk("lit.r11", b0.rd1, 32'h1111_2222);
    cyc(0, 0, 0, 0, 0, 10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
